// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// Holds default sizes, the round-robin pointer type and the tag struct.
package mult_share_pkg;
  localparam int DEF_W        = 32;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MULT_LAT = 2;
  localparam int MAX_IDW      = 3;

  typedef logic [MAX_IDW-1:0] rr_ptr_t;

  typedef struct packed {
    logic    vld;
    rr_ptr_t id;
  } tag_t;
endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searches from ptr_i+1.
// Ports: req_i requests, ptr_i last winner, gnt_o one-hot, idx_o, any_o.
module rr_pick
  import mult_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req_i,
  input  rr_ptr_t         ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output rr_ptr_t         idx_o,
  output logic            any_o
);
  localparam rr_ptr_t LAST = rr_ptr_t'(NREQ - 1);

  rr_ptr_t cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST) ? '0 : cand + rr_ptr_t'(1);
      for (int i = 0; i < NREQ; i++) begin
        if (!any_o && rr_ptr_t'(i) == cand && req_i[i]) begin
          any_o    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = cand;
        end
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined signed multiplier among NREQ requesters, round-robin.
// Ports: req_* operand channels, rsp_* result channel, mult_* multiplier
// side, busy. Optional macro MULT_SHARE_ARBITER_STATS_EN adds stat_issued
// and stat_stall counters.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int W        = DEF_W,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_prod,
  output logic              mult_en,
  output logic [W-1:0]      mult_a,
  output logic [W-1:0]      mult_b,
  input  logic [2*W-1:0]    mult_result,
  output logic              busy
`ifdef MULT_SHARE_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);
  localparam rr_ptr_t LAST = rr_ptr_t'(NREQ - 1);

  tag_t    tag_q [MULT_LAT];
  tag_t    tag_d [MULT_LAT];
  rr_ptr_t ptr_q, ptr_d;

  logic            adv;
  logic            fire;
  logic [NREQ-1:0] pick_gnt;
  rr_ptr_t         pick_idx;
  logic            pick_any;
  logic            unused_id;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign rsp_valid = tag_q[MULT_LAT-1].vld;
  assign rsp_id    = tag_q[MULT_LAT-1].id[IDW-1:0];
  assign rsp_prod  = mult_result;
  assign unused_id = ^tag_q[MULT_LAT-1].id;

  // A pending, unaccepted result freezes the whole pipe.
  assign adv     = !(rsp_valid && !rsp_ready);
  assign mult_en = adv && reset;
  assign fire    = mult_en && pick_any;

  always_comb begin
    req_ready = '0;
    mult_a    = '0;
    mult_b    = '0;
    if (fire) begin
      req_ready = pick_gnt;
      for (int i = 0; i < NREQ; i++) begin
        if (pick_gnt[i]) begin
          mult_a = req_a[i*W +: W];
          mult_b = req_b[i*W +: W];
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MULT_LAT; i++) begin
      busy = busy | tag_q[i].vld;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    tag_d = tag_q;
    if (adv) begin
      tag_d[0].vld = fire;
      tag_d[0].id  = fire ? pick_idx : '0;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
    if (fire) begin
      ptr_d = pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= LAST;
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

`ifdef MULT_SHARE_ARBITER_STATS_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (fire) issued_q <= issued_q + 32'd1;
      if (!adv) stall_q  <= stall_q + 32'd1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a 2-stage multiplier model.
// Table-driven vectors plus directed stall / reset / extreme-value sequences.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_prod;
  logic              mult_en;
  logic [W-1:0]      mult_a, mult_b;
  logic [2*W-1:0]    mult_result;
  logic              busy;
`ifdef MULT_SHARE_ARBITER_STATS_EN
  logic [31:0]       stat_issued, stat_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .MULT_LAT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_prod    (rsp_prod),
    .mult_en     (mult_en),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_result (mult_result),
    .busy        (busy)
`ifdef MULT_SHARE_ARBITER_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  logic signed [63:0] m1, m2;
  always_ff @(posedge clk) begin
    if (mult_en) begin
      m1 <= $signed({{32{mult_a[31]}}, mult_a}) *
            $signed({{32{mult_b[31]}}, mult_b});
      m2 <= m1;
    end
  end
  assign mult_result = m2;

  typedef struct {
    logic [NREQ-1:0]   v;
    logic [NREQ*W-1:0] a;
    logic [NREQ*W-1:0] b;
    logic [NREQ-1:0]   rdy;
    logic              vld;
    logic [IDW-1:0]    id;
    logic [63:0]       prod;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
    input logic [NREQ*W-1:0] b, input logic [NREQ-1:0] rdy,
    input logic vld, input logic [IDW-1:0] id, input logic [63:0] prod);
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.rdy = rdy;
    r.vld = vld; r.id = id; r.prod = prod;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NREQ*W-1:0] A1, B1, A2, B2, A3, B3, AS, BS, AX, BX;

  initial begin
    A1 = {32'd0, 32'd0, 32'd0, 32'd553524};
    B1 = {32'd0, 32'd0, 32'd0, 32'd840};
    A2 = {-32'sd259, -32'sd259, 32'd0, 32'd0};
    B2 = {-32'sd259, 32'sd553524, 32'd0, 32'd0};
    A3 = {32'd4, 32'd3, 32'd2, 32'd1};
    B3 = {32'd5, 32'd4, 32'd3, 32'd2};
    AS = {32'd0, 32'd0, 32'd7, 32'd5};
    BS = {32'd0, 32'd0, -32'sd3, 32'd6};
    AX = {32'd0, 32'd0, 32'd9, 32'h8000_0000};
    BX = {32'd0, 32'd0, 32'd9, 32'h8000_0000};

    tbl[0]  = mk(4'b0001, A1, B1, 4'b0001, 0, 0, 0);
    tbl[1]  = mk(4'b0000, A1, B1, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(4'b1100, A2, B2, 4'b0100, 1, 0, 64'd464960160);
    tbl[3]  = mk(4'b1000, A2, B2, 4'b1000, 0, 0, 0);
    tbl[4]  = mk(4'b0000, A2, B2, 4'b0000, 1, 2, -64'sd143362716);
    tbl[5]  = mk(4'b1111, A3, B3, 4'b0001, 1, 3, 64'd67081);
    tbl[6]  = mk(4'b1111, A3, B3, 4'b0010, 0, 0, 0);
    tbl[7]  = mk(4'b1111, A3, B3, 4'b0100, 1, 0, 64'd2);
    tbl[8]  = mk(4'b1111, A3, B3, 4'b1000, 1, 1, 64'd6);
    tbl[9]  = mk(4'b1111, A3, B3, 4'b0001, 1, 2, 64'd12);
    tbl[10] = mk(4'b0000, A3, B3, 4'b0000, 1, 3, 64'd20);
    tbl[11] = mk(4'b0000, A3, B3, 4'b0000, 1, 0, 64'd2);
    tbl[12] = mk(4'b0000, A3, B3, 4'b0000, 0, 0, 0);

    reset = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_mult_en", mult_en, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].v;
      req_a = tbl[i].a;
      req_b = tbl[i].b;
      @(negedge clk);
      chk($sformatf("t%0d_req_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("t%0d_rsp_valid", i), rsp_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("t%0d_rsp_id", i), rsp_id, tbl[i].id);
        chk($sformatf("t%0d_rsp_prod", i), rsp_prod, tbl[i].prod);
      end
      if (i == 0) chk("t0_mult_a", mult_a, 64'd553524);
      tick();
    end

    req_valid = 4'b0010; req_a = AS; req_b = BS;
    @(negedge clk);
    chk("s0_req_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("s1_rsp_valid", rsp_valid, 0);
    tick();
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_rsp_valid", k), rsp_valid, 1);
      chk($sformatf("stall%0d_rsp_id", k), rsp_id, 1);
      chk($sformatf("stall%0d_rsp_prod", k), rsp_prod, -64'sd21);
      chk($sformatf("stall%0d_req_ready", k), req_ready, 0);
      chk($sformatf("stall%0d_mult_en", k), mult_en, 0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rel_rsp_id", rsp_id, 1);
    chk("rel_rsp_prod", rsp_prod, -64'sd21);
    chk("rel_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rel1_rsp_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("rel2_rsp_valid", rsp_valid, 1);
    chk("rel2_rsp_id", rsp_id, 0);
    chk("rel2_rsp_prod", rsp_prod, 64'd30);
    tick();

    req_valid = 4'b0011; req_a = A3; req_b = B3;
    @(negedge clk);
    chk("r0_req_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("r1_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    reset = 1'b0;
    @(negedge clk);
    chk("r2_busy", busy, 1);
    chk("r2_mult_en", mult_en, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("r3_rsp_valid", rsp_valid, 0);
    chk("r3_busy", busy, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("r%0d_no_rsp", k + 4), rsp_valid, 0);
      tick();
    end

    req_valid = 4'b0011; req_a = AX; req_b = BX;
    @(negedge clk);
    chk("x0_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("x1_rsp_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("x2_rsp_valid", rsp_valid, 1);
    chk("x2_rsp_id", rsp_id, 0);
    chk("x2_rsp_prod", rsp_prod, 64'h4000_0000_0000_0000);
`ifdef MULT_SHARE_ARBITER_STATS_EN
    chk("stat_issued", stat_issued, 1);
    chk("stat_stall", stat_stall, 0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
